// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport and the requester/transmitter side through master.
interface uart_tx_arbiter_if #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int W    = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              tx_start;
    logic [N-1:0]      tx_data;
    logic              tx_ready;
    logic              busy;
    logic [W-1:0]      grant_id;

    modport slave (
        input  req, req_data, tx_ready,
        output ack, tx_start, tx_data, busy, grant_id
    );

    modport master (
        output req, req_data, tx_ready,
        input  ack, tx_start, tx_data, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Serialises NREQ word requesters onto one UART transmitter, one frame at a time.
// Define UART_TX_ARBITER_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int W    = 2
) (
    input  logic             clk,
    input  logic             nrst,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   wait_cnt;
    logic [W-1:0] grant_id;
    logic [N-1:0] tx_data;
    logic [W-1:0] win;
    logic [N-1:0] win_word;
    logic [W-1:0] search_base;

`ifdef UART_TX_ARBITER_RR_EN
    logic [W-1:0] rr_ptr;
    assign search_base = rr_ptr;
`else
    assign search_base = '0;
`endif

    function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        return W'(sum);
    endfunction

    // Scan downwards so the requester closest to search_base is the last to assign and wins.
    always_comb begin
        win = search_base;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[wrap_idx(search_base, k)]) win = wrap_idx(search_base, k);
        end
    end

    assign win_word = bus.req_data[int'(win) * N +: N];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_nxt    = state;
        bus.ack      = '0;
        bus.tx_start = 1'b0;
        unique case (state)
            IDLE: begin
                if ((|bus.req) && bus.tx_ready) state_nxt = LOAD;
            end
            LOAD: begin
                bus.ack[grant_id] = 1'b1;
                state_nxt         = START;
            end
            START: begin
                bus.tx_start = 1'b1;
                state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_ready)          state_nxt = WAIT_DONE;
                else if (wait_cnt == 2'd3)  state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (bus.tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.grant_id = grant_id;
    assign bus.tx_data  = tx_data;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Winner is captured on the edge into LOAD, so grant_id, tx_data and ack all agree during LOAD.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            grant_id <= '0;
            tx_data  <= '0;
        end else if (state == IDLE && state_nxt == LOAD) begin
            grant_id <= win;
            tx_data  <= win_word;
        end
    end

    // Counts tx_ready-high cycles in WAIT_BUSY; the fourth one declares the start lost.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                   wait_cnt <= '0;
        else if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 2'd1;
        else                         wait_cnt <= '0;
    end

`ifdef UART_TX_ARBITER_RR_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr <= '0;
        end else if (state == LOAD) begin
            rr_ptr <= (grant_id == W'(NREQ - 1)) ? '0 : grant_id + W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a frame-age reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int W    = 2;

    typedef enum int {TX_MODEL, TX_DEAD, TX_MANUAL} tx_mode_t;

    logic clk;
    logic nrst;

    uart_tx_arbiter_if #(.N(N), .NREQ(NREQ), .W(W)) bus ();

    uart_tx_arbiter #(.N(N), .NREQ(NREQ), .W(W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int       n_checks = 0;
    int       n_fail   = 0;
    tx_mode_t tx_mode;
    logic     tx_manual;
    int       tx_cnt;
    int       tx_busy_len;
    bit       auto_drop;
    int       ack_cnt [NREQ];
    int       start_cnt;
    int       glog[$];
    int       exp_order[$];

    // Reference model: m_age is cycles into the current frame (0 = idle, 1 = ack, 2 = start, 3.. = waiting).
    int         m_age;
    bit         m_low;
    int         m_gid;
    int         m_ptr;
    logic [N-1:0] m_data;

    function automatic int pick_winner(input logic [NREQ-1:0] r, input int base);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (base + k) % NREQ;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_age = 0; m_low = 0; m_gid = 0; m_ptr = 0; m_data = '0;
        end else if (m_age == 0) begin
            if ((|bus.req) && bus.tx_ready) begin
`ifdef UART_TX_ARBITER_RR_EN
                m_gid = pick_winner(bus.req, m_ptr);
`else
                m_gid = pick_winner(bus.req, 0);
`endif
                m_data = bus.req_data[m_gid * N +: N];
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            m_ptr = (m_gid + 1) % NREQ;
            m_age = 2;
        end else if (m_age == 2) begin
            m_age = 3;
            m_low = 0;
        end else if (!m_low) begin
            if (!bus.tx_ready)   m_low = 1;
            else if (m_age == 6) m_age = 0;
            else                 m_age = m_age + 1;
        end else if (bus.tx_ready) begin
            m_age = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare against the model, log events, then act as requesters and transmitter.
    task automatic tick();
        logic [NREQ-1:0] exp_ack;
        @(negedge clk);
        exp_ack = '0;
        if (m_age == 1) exp_ack[m_gid] = 1'b1;
        check("ack",      32'(bus.ack),      32'(exp_ack));
        check("tx_start", 32'(bus.tx_start), (m_age == 2) ? 1 : 0);
        check("busy",     32'(bus.busy),     (m_age != 0) ? 1 : 0);
        check("grant_id", 32'(bus.grant_id), m_gid);
        check("tx_data",  32'(bus.tx_data),  32'(m_data));
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
                glog.push_back(i);
                ack_cnt[i]++;
            end
        end
        if (bus.tx_start) start_cnt++;
        if (auto_drop) bus.req = bus.req & ~bus.ack;
        case (tx_mode)
            TX_MODEL: begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) bus.tx_ready = 1'b1;
                end else if (bus.tx_start) begin
                    bus.tx_ready = 1'b0;
                    tx_cnt       = tx_busy_len;
                end else begin
                    bus.tx_ready = 1'b1;
                end
            end
            TX_DEAD: bus.tx_ready = 1'b1;
            default: bus.tx_ready = tx_manual;
        endcase
    endtask

    task automatic wait_start(input string name, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.tx_start && n < budget);
        check(name, 32'(bus.tx_start), 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < budget);
        check(name, 32'(bus.busy), 0);
    endtask

    task automatic wait_grants(input string name, input int count, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (glog.size() < count && n < budget);
        check(name, glog.size(), count);
    endtask

    task automatic clear_ack_cnt();
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
    endtask

    initial begin
        nrst         = 1'b1;
        bus.req      = '0;
        bus.req_data = 32'hD3C2_B1A5;
        bus.tx_ready = 1'b1;
        tx_mode      = TX_MODEL;
        tx_manual    = 1'b1;
        tx_cnt       = 0;
        tx_busy_len  = 12;
        auto_drop    = 1'b1;
        start_cnt    = 0;
        clear_ack_cnt();
`ifdef UART_TX_ARBITER_RR_EN
        exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
        exp_order.push_back(3); exp_order.push_back(0);
`else
        exp_order.push_back(0); exp_order.push_back(0); exp_order.push_back(0);
`endif
        #1 nrst = 1'b0;
        repeat (3) tick();
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_grant_id", 32'(bus.grant_id), 0);
        nrst = 1'b1;
        tick();

        // Single request from index 0: ack one cycle after sampling, start the cycle after.
        bus.req = 4'b0001;
        tick();
        check("first_ack", 32'(bus.ack), 32'h1);
        tick();
        check("first_tx_start", 32'(bus.tx_start), 1);
        check("first_tx_data", 32'(bus.tx_data), 32'hA5);
        check("first_grant_id", 32'(bus.grant_id), 0);
        wait_idle("first_idle", 60);

        // All requesters held: arbitration order across consecutive frames.
        glog.delete();
        auto_drop = 1'b0;
        bus.req   = 4'b1111;
        wait_grants("held_grants", exp_order.size(), 400);
        bus.req   = '0;
        auto_drop = 1'b1;
        for (int k = 0; k < exp_order.size(); k++) begin
            if (k < glog.size()) check("grant_order", glog[k], exp_order[k]);
        end
        wait_idle("held_idle", 60);

        // Transmitter never responds: four WAIT_BUSY cycles, then IDLE with no re-ack.
        tx_mode = TX_DEAD;
        clear_ack_cnt();
        bus.req = 4'b0010;
        wait_start("lost_start", 20);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("lost_wait_busy", 32'(bus.busy), 1);
        end
        tick();
        check("lost_busy_drop", 32'(bus.busy), 0);
        repeat (10) tick();
        check("lost_single_ack", ack_cnt[1], 1);
        tx_mode = TX_MODEL;
        tick();

        // Request while transmitter busy: ack only the cycle after tx_ready returns.
        tx_mode   = TX_MANUAL;
        tx_manual = 1'b0;
        tick();
        clear_ack_cnt();
        bus.req = 4'b0100;
        repeat (5) tick();
        check("blocked_no_ack", ack_cnt[2], 0);
        tx_manual = 1'b1;
        tick();
        check("blocked_pre_ack", 32'(bus.ack), 0);
        tick();
        check("blocked_ack", 32'(bus.ack), 32'h4);
        tx_mode = TX_MODEL;
        wait_idle("blocked_idle", 60);

        // Reset asserted in WAIT_DONE clears outputs at once; nothing starts afterwards with req low.
        bus.req = 4'b1000;
        wait_start("rst_start", 20);
        tick();
        tick();
        check("rst_in_wait_done", 32'(bus.busy), 1);
        check("rst_pre_data", 32'(bus.tx_data), 32'hD3);
        #2 nrst = 1'b0;
        #1;
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_tx_start", 32'(bus.tx_start), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        start_cnt = 0;
        tick();
        tick();
        nrst = 1'b1;
        repeat (30) tick();
        check("rst_no_start", start_cnt, 0);

        // A one-cycle request pulse during WAIT_DONE is never served.
        clear_ack_cnt();
        bus.req = 4'b0001;
        wait_start("pulse_start", 20);
        tick();
        tick();
        check("pulse_in_wait_done", 32'(bus.busy), 1);
        bus.req[2] = 1'b1;
        tick();
        bus.req[2] = 1'b0;
        wait_idle("pulse_idle", 60);
        repeat (5) tick();
        check("pulse_not_served", ack_cnt[2], 0);
        check("pulse_frame_acked", ack_cnt[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
